// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit: 32-cycle shift-add UMULL/SMULL and restoring UDIV,
// followed by two register-file writeback cycles (RdLo, then RdHi with optional N/Z flags).
`timescale 1ns/1ps

module mdu_seq (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_set_flags,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_illegal,
    output logic        o_reg_we,
    output logic        o_wr_hi,
    output logic [31:0] o_wr_data,
    output logic [31:0] o_lo,
    output logic [31:0] o_hi,
    output logic        o_flag_n,
    output logic        o_flag_z,
    output logic [1:0]  o_flag_we
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_WB_LO = 2'd2;
    localparam logic [1:0] S_WB_HI = 2'd3;

    localparam logic [1:0] OP_UMULL = 2'b00;
    localparam logic [1:0] OP_SMULL = 2'b01;
    localparam logic [1:0] OP_UDIV  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic [1:0]  r_op;
    logic        r_sf;
    logic        r_neg;
    logic [31:0] r_opnd;
    logic [63:0] r_acc;
    logic [31:0] r_lo;
    logic [31:0] r_hi;
    logic        r_illegal;
    logic        r_flag_n;
    logic        r_flag_z;

    logic        w_idle;
    logic        w_accept;
    logic        w_illegal_req;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic [63:0] w_div_next;
    logic [63:0] w_acc_next;
    logic [63:0] w_result;
    logic        w_wb;

    assign w_idle        = (r_state == S_IDLE);
    assign w_accept      = w_idle && i_start && (i_op != OP_RSVD) && !i_flush;
    assign w_illegal_req = w_idle && i_start && (i_op == OP_RSVD) && !i_flush;

    // SMULL works on magnitudes; 0x80000000 stays 2^31 when read as unsigned.
    assign w_a_neg = (i_op == OP_SMULL) && i_a[31];
    assign w_b_neg = (i_op == OP_SMULL) && i_b[31];
    assign w_a_mag = w_a_neg ? (~i_a + 32'd1) : i_a;
    assign w_b_mag = w_b_neg ? (~i_b + 32'd1) : i_b;

    // Multiply: acc = {partial, multiplier}, add multiplicand on LSB then shift right.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opnd : 32'd0)};
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Divide: acc = {remainder, dividend/quotient}; a zero divisor yields all-ones and rem=a.
    assign w_rem_sh   = {r_acc[63:32], r_acc[31]};
    assign w_diff     = w_rem_sh - {1'b0, r_opnd};
    assign w_div_next = w_diff[32] ? {w_rem_sh[31:0], r_acc[30:0], 1'b0}
                                   : {w_diff[31:0],   r_acc[30:0], 1'b1};

    assign w_acc_next = (r_op == OP_UDIV) ? w_div_next : w_mul_next;
    assign w_result   = r_neg ? (~w_acc_next + 64'd1) : w_acc_next;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 6'd0;
            r_op      <= OP_UMULL;
            r_sf      <= 1'b0;
            r_neg     <= 1'b0;
            r_opnd    <= 32'd0;
            r_acc     <= 64'd0;
            r_lo      <= 32'd0;
            r_hi      <= 32'd0;
            r_illegal <= 1'b0;
            r_flag_n  <= 1'b0;
            r_flag_z  <= 1'b0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
            r_illegal <= w_illegal_req;
            if (i_flush) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_state <= S_CALC;
                            r_cnt   <= 6'd0;
                            r_op    <= i_op;
                            r_sf    <= i_set_flags;
                            r_neg   <= w_a_neg ^ w_b_neg;
                            if (i_op == OP_UDIV) begin
                                r_opnd <= i_b;
                                r_acc  <= {32'd0, i_a};
                            end else begin
                                r_opnd <= w_a_mag;
                                r_acc  <= {32'd0, w_b_mag};
                            end
                        end
                    end
                    S_CALC: begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'd31) begin
                            r_state <= S_WB_LO;
                            r_lo    <= w_result[31:0];
                            r_hi    <= w_result[63:32];
                        end
                    end
                    S_WB_LO: begin
                        r_state  <= S_WB_HI;
                        r_flag_n <= r_hi[31];
                        r_flag_z <= ({r_hi, r_lo} == 64'd0);
                    end
                    S_WB_HI: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Writeback strobes drop in the same cycle flush is raised.
    assign w_wb = ((r_state == S_WB_LO) || (r_state == S_WB_HI)) && !i_flush;

    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        o_wr_data = 32'd0;
        if (r_state == S_WB_LO) begin
            o_wr_data = r_lo;
        end else if (r_state == S_WB_HI) begin
            o_wr_data = r_hi;
        end
    end

    assign o_busy    = !w_idle;
    assign o_reg_we  = w_wb;
    assign o_wr_hi   = (r_state == S_WB_HI);
    assign o_done    = (r_state == S_WB_HI) && !i_flush;
    assign o_flag_we = ((r_state == S_WB_HI) && !i_flush && r_sf && !r_op[1]) ? 2'b11 : 2'b00;
    assign o_illegal = r_illegal;
    assign o_lo      = r_lo;
    assign o_hi      = r_hi;
    assign o_flag_n  = r_flag_n;
    assign o_flag_z  = r_flag_z;

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: directed corner cases plus random operations against an arithmetic model.
`timescale 1ns/1ps

module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        sf;
    logic        flush;
    logic        busy;
    logic        done;
    logic        illegal;
    logic        reg_we;
    logic        wr_hi;
    logic [31:0] wr_data;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        flag_n;
    logic        flag_z;
    logic [1:0]  flag_we;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] prev_lo = 32'd0;
    logic [31:0] prev_hi = 32'd0;

    mdu_seq dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_op        (op),
        .i_a         (a),
        .i_b         (b),
        .i_set_flags (sf),
        .i_flush     (flush),
        .o_busy      (busy),
        .o_done      (done),
        .o_illegal   (illegal),
        .o_reg_we    (reg_we),
        .o_wr_hi     (wr_hi),
        .o_wr_data   (wr_data),
        .o_lo        (lo),
        .o_hi        (hi),
        .o_flag_n    (flag_n),
        .o_flag_z    (flag_z),
        .o_flag_we   (flag_we)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result as {hi, lo}, straight from the arithmetic definition of each op.
    function automatic logic [63:0] model(input logic [1:0] m_op, input logic [31:0] m_a,
                                          input logic [31:0] m_b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{m_a[31]}}, m_a};
        sb = {{32{m_b[31]}}, m_b};
        case (m_op)
            2'b00:   return {32'd0, m_a} * {32'd0, m_b};
            2'b01:   return sa * sb;
            default: return (m_b == 32'd0) ? {m_a, 32'hFFFF_FFFF} : {m_a % m_b, m_a / m_b};
        endcase
    endfunction

    // Called at 1 time unit after a rising edge; returns at the same phase.
    task automatic run_op(input logic [1:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                          input logic t_sf, input int inj_cyc, input int flush_cyc);
        logic [63:0] exp;
        logic [1:0]  exp_fwe;
        exp     = model(t_op, t_a, t_b);
        exp_fwe = (t_op != 2'b10 && t_sf) ? 2'b11 : 2'b00;
        op = t_op; a = t_a; b = t_b; sf = t_sf; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            start = (c == inj_cyc);
            if (c == inj_cyc) begin
                op = 2'($urandom_range(0, 2)); a = $urandom; b = $urandom; sf = 1'b1;
            end
            flush = (flush_cyc > 0) && (c == flush_cyc);
            if (flush_cyc > 0 && c > flush_cyc) begin
                check("flushed_ctl", {59'd0, busy, reg_we, done, flag_we}, 64'd0);
            end else if (c <= 32) begin
                check("calc_ctl", {59'd0, busy, reg_we, done, flag_we}, 64'h10);
            end else if (c == 33) begin
                check("wblo_ctl", {58'd0, busy, reg_we, wr_hi, done, flag_we}, 64'h30);
                check("wblo_data", {32'd0, wr_data}, {32'd0, exp[31:0]});
            end else if (c == 34) begin
                check("wbhi_ctl", {60'd0, busy, reg_we, wr_hi, done}, 64'hF);
                check("wbhi_data", {32'd0, wr_data}, {32'd0, exp[63:32]});
                check("wbhi_flag_we", {62'd0, flag_we}, {62'd0, exp_fwe});
                check("wbhi_flag_n", {63'd0, flag_n}, {63'd0, exp[63]});
                check("wbhi_flag_z", {63'd0, flag_z}, {63'd0, (exp == 64'd0)});
                check("result_lo", {32'd0, lo}, {32'd0, exp[31:0]});
                check("result_hi", {32'd0, hi}, {32'd0, exp[63:32]});
            end else begin
                check("post_idle", {61'd0, busy, reg_we, done}, 64'd0);
                prev_lo = exp[31:0];
                prev_hi = exp[63:32];
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        flush = 1'b0;
        check("hold_lo", {32'd0, lo}, {32'd0, prev_lo});
        check("hold_hi", {32'd0, hi}, {32'd0, prev_hi});
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0; sf = 1'b0; flush = 1'b0;
        #12;
        check("rst_ctl", {57'd0, busy, done, illegal, reg_we, wr_hi, flag_n, flag_z}, 64'd0);
        check("rst_data", {wr_data, lo}, 64'd0);
        check("rst_hi_fwe", {30'd0, hi, flag_we}, 64'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 0);
        run_op(2'b01, 32'hFFFF_FFFE, 32'd3, 1'b1, 0, 0);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, 0);
        run_op(2'b01, 32'h8000_0000, 32'd1, 1'b1, 0, 0);
        run_op(2'b10, 32'd100, 32'd7, 1'b1, 0, 0);
        run_op(2'b10, 32'd5, 32'd0, 1'b0, 0, 0);
        run_op(2'b00, 32'd0, 32'd1234, 1'b1, 0, 0);

        // Starts during CALC and during WB_HI must be dropped.
        run_op(2'b00, 32'd12345, 32'd678, 1'b1, 5, 0);
        run_op(2'b10, 32'hDEAD_BEEF, 32'd99, 1'b0, 34, 0);

        // Flush mid-CALC leaves the previous result in place.
        run_op(2'b01, 32'd7, 32'd9, 1'b1, 0, 10);

        // Reserved opcode.
        op = 2'b11; a = 32'd1; b = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("illegal_pulse", {63'd0, illegal}, 64'd1);
        check("illegal_ctl", {61'd0, busy, reg_we, done}, 64'd0);
        check("illegal_lo", {32'd0, lo}, {32'd0, prev_lo});
        @(posedge clk); #1;
        check("illegal_end", {62'd0, illegal, busy}, 64'd0);

        for (int i = 0; i < 10; i++) begin
            logic [1:0]  r_op;
            logic [31:0] r_b;
            r_op = 2'($urandom_range(0, 2));
            r_b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            run_op(r_op, $urandom, r_b, 1'($urandom_range(0, 1)), 0, 0);
        end

        // Asynchronous reset at CALC cycle 20, between clock edges.
        op = 2'b00; a = 32'hFFFF_0000; b = 32'h1234_5678; sf = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("arst_ctl", {57'd0, busy, done, illegal, reg_we, wr_hi, flag_n, flag_z}, 64'd0);
        check("arst_data", {wr_data, lo}, 64'd0);
        check("arst_hi_fwe", {30'd0, hi, flag_we}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        prev_lo = 32'd0;
        prev_hi = 32'd0;
        @(posedge clk); #1;
        check("arst_idle", {63'd0, busy}, 64'd0);
        run_op(2'b00, 32'd3, 32'd4, 1'b0, 0, 0);
        check("final_lo", {32'd0, lo}, 64'd12);
        check("final_hi", {32'd0, hi}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
